bfloat_mul_pipe: RTL and testbench

- Pipelined bfloat16 multiplier: the stage directly upstream of the bfloat16 adder in the CNN MAC datapath.
- Takes activation/weight operand pairs and produces one bfloat16 product per cycle; the product feeds the adder's accumulation input.
- Uses valid/ready handshakes on both sides.
- Shares the adder's number format: 1 sign, 8 exponent (bias 127), 7 fraction bits.

---
 rtl/bfloat_mul_pipe.sv | 157 +++++++++++++++
 tb/tb_bfloat_mul_pipe.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfloat_mul_pipe.sv
// bfloat_mul_pipe
// Three-stage pipelined bfloat16 multiplier (1 sign, 8 exponent bias 127, 7 fraction bits).
// Feeds the accumulation input of the bfloat16 adder in the CNN MAC datapath.
//   S1: unpack/classify   S2: 8x8 mantissa multiply, exponent sum   S3: normalize/round/pack
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair on a/b is valid
//   in_ready   block accepts a/b this cycle
//   a, b       bfloat16 operands
//   out_valid  out holds a valid product
//   out_ready  downstream accepts out this cycle
//   out        bfloat16 product (S3 register)
// Denormal inputs are flushed to zero, no denormal outputs, round-to-nearest-even.
`timescale 1ns/1ps
module bfloat_mul_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out
);

    typedef enum logic [1:0] {KNorm, KZero, KInf, KNan} kind_e;

    // Stage registers
    logic               r1_valid, r2_valid, r3_valid;
    logic               r1_sign, r2_sign;
    kind_e              r1_kind, r2_kind;
    logic [7:0]         r1_ea, r1_eb, r1_ma, r1_mb;
    logic signed [9:0]  r2_exp;
    logic [15:0]        r2_prod;
    logic [15:0]        r3_out;

    // Combinational signals
    logic               w_adv;
    logic               w_a_zero, w_a_inf, w_a_nan, w_b_zero, w_b_inf, w_b_nan;
    kind_e              w_kind;
    logic signed [9:0]  w_exp_sum;
    logic [15:0]        w_prod;
    logic signed [9:0]  w_exp_n, w_exp_f;
    logic [6:0]         w_frac;
    logic               w_guard, w_sticky, w_inc;
    logic [7:0]         w_frac_r;
    logic [15:0]        w_res;

    // Whole pipe freezes only when a finished result is refused downstream;
    // in_ready never depends on in_valid.
    assign w_adv     = !(r3_valid && !out_ready);
    assign in_ready  = w_adv;
    assign out_valid = r3_valid;
    assign out       = r3_out;

    // S1: classification
    assign w_a_zero = (a[14:7] == 8'h00);
    assign w_a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'h00);
    assign w_a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'h00);
    assign w_b_zero = (b[14:7] == 8'h00);
    assign w_b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'h00);
    assign w_b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'h00);

    always_comb begin
        w_kind = KNorm;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_kind = KNan;
        end else if (w_a_inf || w_b_inf) begin
            w_kind = KInf;
        end else if (w_a_zero || w_b_zero) begin
            w_kind = KZero;
        end
    end

    // S2: exponent sum (range -125..381, no wrap in 10 signed bits) and mantissa product
    assign w_exp_sum = $signed({2'b00, r1_ea}) + $signed({2'b00, r1_eb}) - 10'sd127;
    assign w_prod    = 16'(r1_ma) * 16'(r1_mb);

    // S3: normalize, round to nearest even, pack
    always_comb begin
        if (r2_prod[15]) begin
            w_frac   = r2_prod[14:8];
            w_guard  = r2_prod[7];
            w_sticky = |r2_prod[6:0];
            w_exp_n  = r2_exp + 10'sd1;
        end else begin
            w_frac   = r2_prod[13:7];
            w_guard  = r2_prod[6];
            w_sticky = |r2_prod[5:0];
            w_exp_n  = r2_exp;
        end
        w_inc    = w_guard && (w_sticky || w_frac[0]);
        w_frac_r = {1'b0, w_frac} + {7'd0, w_inc};
        // Carry out of the fraction leaves frac_r[6:0]=0 and bumps the exponent
        w_exp_f  = w_frac_r[7] ? (w_exp_n + 10'sd1) : w_exp_n;

        w_res = 16'h0000;
        unique case (r2_kind)
            KNan:  w_res = 16'h7FC0;
            KInf:  w_res = {r2_sign, 8'hFF, 7'h00};
            KZero: w_res = {r2_sign, 15'h0000};
            KNorm: begin
                if (w_exp_f >= 10'sd255) begin
                    w_res = {r2_sign, 8'hFF, 7'h00};
                end else if (w_exp_f <= 10'sd0) begin
                    w_res = {r2_sign, 15'h0000};
                end else begin
                    w_res = {r2_sign, w_exp_f[7:0], w_frac_r[6:0]};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r3_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r2_sign  <= 1'b0;
            r1_kind  <= KNorm;
            r2_kind  <= KNorm;
            r1_ea    <= 8'h00;
            r1_eb    <= 8'h00;
            r1_ma    <= 8'h00;
            r1_mb    <= 8'h00;
            r2_exp   <= 10'sd0;
            r2_prod  <= 16'h0000;
            r3_out   <= 16'h0000;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            r2_valid <= r1_valid;
            r3_valid <= r2_valid;
            // Data only moves with a valid token; bubbles leave it untouched
            if (in_valid) begin
                r1_sign <= a[15] ^ b[15];
                r1_kind <= w_kind;
                r1_ea   <= a[14:7];
                r1_eb   <= b[14:7];
                r1_ma   <= {1'b1, a[6:0]};
                r1_mb   <= {1'b1, b[6:0]};
            end
            if (r1_valid) begin
                r2_sign <= r1_sign;
                r2_kind <= r1_kind;
                r2_exp  <= w_exp_sum;
                r2_prod <= w_prod;
            end
            if (r2_valid) begin
                r3_out <= w_res;
            end
        end
    end

endmodule

// File: tb/tb_bfloat_mul_pipe.sv
// Self-checking bench for bfloat_mul_pipe. Expected products come from a real-arithmetic
// reference: operands are widened to doubles, multiplied exactly, and the double is rounded
// to bfloat16 with round-to-nearest-even and the flush/saturate rules.
`timescale 1ns/1ps
module tb_bfloat_mul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];

    bfloat_mul_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Exact value of a normal bfloat16 as a double
    function automatic real bf_to_real(input logic [15:0] x);
        logic [63:0] d;
        d = {x[15], 11'(int'(x[14:7]) - 127 + 1023), x[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        logic        s, xz, xi, xn, yz, yi, yn, g, st;
        logic [63:0] d;
        logic [7:0]  fr;
        int          e;
        s  = x[15] ^ y[15];
        xz = (x[14:7] == 8'h00);
        yz = (y[14:7] == 8'h00);
        xi = (x[14:7] == 8'hFF) && (x[6:0] == 7'h00);
        yi = (y[14:7] == 8'hFF) && (y[6:0] == 7'h00);
        xn = (x[14:7] == 8'hFF) && (x[6:0] != 7'h00);
        yn = (y[14:7] == 8'hFF) && (y[6:0] != 7'h00);
        if (xn || yn || (xi && yz) || (yi && xz)) return 16'h7FC0;
        if (xi || yi) return {s, 8'hFF, 7'h00};
        if (xz || yz) return {s, 15'h0000};
        d  = $realtobits(bf_to_real(x) * bf_to_real(y));
        e  = int'(d[62:52]) - 1023 + 127;
        fr = {1'b0, d[51:45]};
        g  = d[44];
        st = |d[43:0];
        if (g && (st || fr[0])) fr = fr + 8'd1;
        if (fr[7]) begin
            fr = 8'd0;
            e  = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 7'h00};
        if (e <= 0) return {s, 15'h0000};
        return {s, e[7:0], fr[6:0]};
    endfunction

    // Mostly moderate exponents so the normal path dominates, with some specials mixed in
    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 3) != 0) v[14:7] = 8'($urandom_range(100, 154));
        if ($urandom_range(0, 15) == 0) v[14:7] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        return v;
    endfunction

    // One cycle of stimulus: drive at the falling edge, let in_ready settle, and record the
    // model result of any pair the coming rising edge will accept.
    task automatic tick(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        out_ready = ordy;
        #1;
        if (in_valid && in_ready) exp_q.push_back(ref_mul(ia, ib));
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_tests++;
        if (out !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_out: got %h want 0000", out);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        tick(1'b1, 16'h3FC0, 16'h4000, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b1);
            n_tests++;
            if (out_valid !== (k == 3)) begin
                n_fail++;
                $display("FAIL single_latency k=%0d: out_valid %b want %b", k, out_valid, k == 3);
            end
            if (k == 3) begin
                n_tests++;
                if (out !== 16'h4040) begin
                    n_fail++;
                    $display("FAIL single_value: got %h want 4040", out);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa[4] = '{16'h3FC0, 16'h3FFF, 16'hBFC0, 16'h3F81};
        logic [15:0] pb[4] = '{16'h3FC1, 16'h3FFF, 16'h3FC0, 16'h3F81};
        logic [15:0] pr[4] = '{16'h4011, 16'h407E, 16'hC010, 16'h3F82};
        for (int i = 0; i < 9; i++) begin
            if (i < 4) tick(1'b1, pa[i], pb[i], 1'b1);
            else       tick(1'b0, 16'h0, 16'h0, 1'b1);
            n_tests++;
            if (out_valid !== (i >= 3 && i <= 6)) begin
                n_fail++;
                $display("FAIL b2b_valid i=%0d: got %b want %b", i, out_valid, i >= 3 && i <= 6);
            end
            if (i >= 3 && i <= 6) begin
                n_tests++;
                if (out !== pr[i-3]) begin
                    n_fail++;
                    $display("FAIL b2b_value #%0d: got %h want %h", i - 3, out, pr[i-3]);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_specials();
        logic [15:0] pa[6] = '{16'h7F00, 16'h0080, 16'h7F80, 16'hFF80, 16'h0001, 16'h7FC1};
        logic [15:0] pb[6] = '{16'h4000, 16'h3F00, 16'h0000, 16'h4000, 16'h3F80, 16'h3F80};
        logic [15:0] pr[6] = '{16'h7F80, 16'h0000, 16'h7FC0, 16'hFF80, 16'h0000, 16'h7FC0};
        for (int i = 0; i < 10; i++) begin
            if (i < 6) tick(1'b1, pa[i], pb[i], 1'b1);
            else       tick(1'b0, 16'h0, 16'h0, 1'b1);
            if (i >= 3 && i <= 8) begin
                n_tests++;
                if (out_valid !== 1'b1 || out !== pr[i-3]) begin
                    n_fail++;
                    $display("FAIL special %h*%h: got valid=%b out=%h want valid=1 out=%h",
                             pa[i-3], pb[i-3], out_valid, out, pr[i-3]);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [15:0] e;
        int          cnt;
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, rand_op(), rand_op(), $urandom_range(0, 9) < 7);
            n_tests++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_fail++;
                $display("FAIL rand_in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                n_tests++;
                e = exp_q.size() != 0 ? exp_q.pop_front() : 16'hxxxx;
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL rand_value: got %h want %h", out, e);
                end
            end
        end
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 30) begin
            tick(1'b0, 16'h0, 16'h0, 1'b1);
            cnt++;
            if (out_valid) begin
                n_tests++;
                e = exp_q.pop_front();
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL rand_drain: got %h want %h", out, e);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_lost: %0d results never appeared, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [15:0] pa[4];
        logic [15:0] pb[4];
        logic [15:0] e;
        logic [15:0] prev_out;
        logic        prev_stall, ordy;
        int          sent, got;
        for (int i = 0; i < 4; i++) begin
            pa[i] = rand_op();
            pb[i] = rand_op();
        end
        sent       = 0;
        got        = 0;
        prev_stall = 1'b0;
        prev_out   = 16'h0;
        for (int c = 0; c < 25; c++) begin
            ordy = !(c >= 2 && c <= 7);
            if (sent < 4) tick(1'b1, pa[sent], pb[sent], ordy);
            else          tick(1'b0, 16'h0, 16'h0, ordy);
            if (in_valid && in_ready) sent++;
            n_tests++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_fail++;
                $display("FAIL bp_in_ready c=%0d: got %b want %b", c, in_ready,
                         !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                n_tests++;
                if (out_valid !== 1'b1 || out !== prev_out) begin
                    n_fail++;
                    $display("FAIL bp_hold c=%0d: got valid=%b out=%h want valid=1 out=%h",
                             c, out_valid, out, prev_out);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                got++;
                e = exp_q.size() != 0 ? exp_q.pop_front() : 16'hxxxx;
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL bp_value #%0d: got %h want %h", got, out, e);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
        end
        n_tests++;
        if (got != 4 || sent != 4) begin
            n_fail++;
            $display("FAIL bp_count: sent %0d received %0d want 4 and 4", sent, got);
        end
        exp_q.delete();
    endtask

    task automatic test_bubbles();
        logic        pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        want;
        logic [15:0] e;
        for (int i = 0; i < 9; i++) begin
            if (i < 4) tick(pat[i], rand_op(), rand_op(), 1'b1);
            else       tick(1'b0, 16'h0, 16'h0, 1'b1);
            want = (i >= 3 && i <= 6) ? pat[i-3] : 1'b0;
            n_tests++;
            if (out_valid !== want) begin
                n_fail++;
                $display("FAIL bubble_valid i=%0d: got %b want %b", i, out_valid, want);
            end
            if (out_valid && want) begin
                n_tests++;
                e = exp_q.size() != 0 ? exp_q.pop_front() : 16'hxxxx;
                if (out !== e) begin
                    n_fail++;
                    $display("FAIL bubble_value i=%0d: got %h want %h", i, out, e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) tick(1'b1, 16'h3FC0 + 16'(i), 16'h4000, 1'b1);
        // Third pair is captured here; all three stages now hold valid data
        @(posedge clk);
        #2;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_before: out_valid %b want 1", out_valid);
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstmid_async: got valid=%b out=%h want valid=0 out=0000",
                     out_valid, out);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b1);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_stale k=%0d: out_valid %b want 0", k, out_valid);
            end
        end
        tick(1'b1, 16'h3FC0, 16'h4000, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick(1'b0, 16'h0, 16'h0, 1'b1);
            n_tests++;
            if (out_valid !== (k == 3) || (k == 3 && out !== 16'h4040)) begin
                n_fail++;
                $display("FAIL rstmid_after k=%0d: got valid=%b out=%h want valid=%b out=4040",
                         k, out_valid, out, k == 3);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_specials();
        test_bubbles();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
